// File: rtl/als_spi_responder.sv
// SPI responder standing in for the Pmod ALS light-sensor ADC (lead zeros, sample MSB-first, trail zeros).
// Latency: outputs react SYNC_STAGES+1 clk cycles after an sclk_in/cs_n_in pin edge.
// Backpressure: none; the master paces the frame, and sample_load is accepted on any cycle.
module als_spi_responder #(
  parameter int DATA_BITS   = 8,
  parameter int LEAD_ZEROS  = 3,
  parameter int TRAIL_ZEROS = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk_in,
  input  logic                 cs_n_in,
  input  logic [DATA_BITS-1:0] sample_data,
  input  logic                 sample_load,
  output logic                 miso,
  output logic                 miso_oe,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_error,
  output logic [15:0]          frame_count
);

  localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS + TRAIL_ZEROS;
  localparam int CW         = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_RISE = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync;
  logic [SYNC_STAGES-1:0]  cs_sync;
  logic                    sclk_d;
  logic                    cs_d;
  logic [DATA_BITS-1:0]    hold_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [CW-1:0]           rise_cnt;

  logic                    sclk_s;
  logic                    cs_s;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    cs_fall;
  logic                    cs_rise;
  logic [DATA_BITS-1:0]    load_vec;
  logic [FRAME_BITS-1:0]   frame_vec;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // A load coinciding with the frame start bypasses the hold register so the new sample is sent.
  assign load_vec  = sample_load ? sample_data : hold_q;
  assign frame_vec = {{LEAD_ZEROS{1'b0}}, load_vec, {TRAIL_ZEROS{1'b0}}};

  // Synchronize the asynchronous master pins and keep one extra delay flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Sample hold register; the frame in flight keeps its own copy in shift_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (sample_load) begin
      hold_q <= sample_data;
    end
  end

  // Frame FSM: miso changes on sclk falls, rises are counted to detect the end of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shift_q     <= '0;
      rise_cnt    <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          busy    <= 1'b0;
          if (cs_fall) begin
            shift_q  <= frame_vec;
            miso     <= frame_vec[FRAME_BITS-1];
            rise_cnt <= '0;
            miso_oe  <= 1'b1;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_rise && rise_cnt == LAST_RISE) begin
            // Final rise wins over a simultaneous chip-select release: the frame is complete.
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            rise_cnt    <= rise_cnt + 1'b1;
            miso        <= 1'b0;
            if (cs_rise) begin
              miso_oe <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              state   <= DONE;
            end
          end else if (cs_rise) begin
            frame_error <= 1'b1;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (sclk_rise) begin
            rise_cnt <= rise_cnt + 1'b1;
          end else if (sclk_fall && rise_cnt != '0) begin
            // A fall before the first rise would skip the leading bit, so it is ignored.
            miso    <= shift_q[FRAME_BITS-2];
            shift_q <= shift_q << 1;
          end
        end
        DONE: begin
          miso <= 1'b0;
          busy <= 1'b1;
          if (cs_rise) begin
            miso_oe <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/als_spi_responder.md
Name: als_spi_responder

Overview:
- Synchronous SPI slave model of the Pmod ALS light-sensor ADC, driven by our SPI master's chip-select and divided serial clock.
- Answers each chip-select frame with the sensor bit pattern: LEAD_ZEROS zeros, then DATA_BITS sample bits MSB-first, then TRAIL_ZEROS zeros.
- Used as the on-chip loopback target and as the sensor stand-in for master-side benches.
- Oversamples sclk_in and cs_n_in on the system clock; no logic is clocked by sclk_in.

Parameters:
DATA_BITS, 8, width of the light sample.
LEAD_ZEROS, 3, zero bits driven before the sample MSB.
TRAIL_ZEROS, 4, zero bits driven after the sample LSB.
SYNC_STAGES, 2, synchronizer flops on sclk_in and cs_n_in (minimum 2).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
sclk_in  input  1  serial clock from the master (asynchronous to clk).
cs_n_in  input  1  chip select from the master, active-low (asynchronous).
sample_data  input  DATA_BITS  next light sample.
sample_load  input  1  captures sample_data into the hold register.
miso  output  1  serial data to the master.
miso_oe  output  1  high while the synchronized chip select is active.
busy  output  1  high in SHIFT and DONE.
frame_done  output  1  one-cycle pulse when a frame completes.
frame_error  output  1  one-cycle pulse when chip select rises before the frame completes.
frame_count  output  16  count of completed frames.

Behaviour:
- Reset values: miso=0, miso_oe=0, busy=0, frame_done=0, frame_error=0, frame_count=0, hold register=0, state=IDLE. The synchronizer chains reset to sclk=0 and cs_n=1.
- Synchronization and edge detection: sclk_in and cs_n_in each pass through SYNC_STAGES flops. Edges are detected between the last sync stage and one extra delay flop.
- Response latency: registered outputs update on the clk edge after edge detection, i.e. SYNC_STAGES+1 clk cycles after the pin edge.
- Clock-rate requirement: each sclk_in high and low phase lasts at least SYNC_STAGES+2 clk cycles. The bench enforces this.
- FRAME_BITS = LEAD_ZEROS+DATA_BITS+TRAIL_ZEROS (15 by default).
- Shift vector: {LEAD_ZEROS zeros, sample, TRAIL_ZEROS zeros}, shifted MSB-first.
- Bit timing: miso changes on detected sclk falls; the master samples on sclk rises.
- State IDLE:
  - miso=0 and miso_oe=0.
  - On a detected cs_n fall: load the shift vector from the hold register, drive bit 0 (a zero), clear the rise counter, set miso_oe=1, go to SHIFT.
- State SHIFT:
  - On each detected sclk rise: increment the rise counter.
  - On each detected sclk fall: shift the next bit onto miso. A fall that occurs before the first rise is ignored.
  - When the rise counter reaches FRAME_BITS: pulse frame_done, increment frame_count, go to DONE.
- State DONE:
  - miso=0 and busy=1.
  - Extra sclk edges are ignored.
  - On a detected cs_n rise: go to IDLE with miso_oe=0 and busy=0.
- Early chip-select release: a cs_n rise while in SHIFT pulses frame_error, goes to IDLE, and leaves frame_count unchanged.
- Hold register:
  - sample_load=1 captures sample_data on that clk edge.
  - Loads during SHIFT or DONE do not alter the frame in flight; they apply to the next frame.
- Simultaneous sample_load and detected cs_n fall in the same cycle: the frame uses the new sample_data (bypass), and the hold register also captures it.
- Simultaneous final sclk rise and cs_n rise in the same cycle: the frame counts as completed (frame_done), not errored, and the state goes directly to IDLE.
- frame_count wraps 16'hFFFF -> 16'h0000.
- Reset mid-frame: asynchronous return to the reset values; the next frame begins only after a fresh cs_n fall is detected.
- sclk edges while in IDLE are ignored.

Test Plan:
- Reset, then sample_load with 8'hA5 and run one 16-clock frame (sclk half-period 20 clk cycles). Required: master-captured 16 bits = 000_10100101_0000_0 (the 16th clock reads 0), one frame_done pulse, frame_count=1.
- Load 8'h3C, then pulse sample_load with 8'hFF mid-frame. Required: this frame returns 8'h3C; the next frame returns 8'hFF.
- Raise cs_n after 6 sclk rises. Required: one frame_error pulse, no frame_done, frame_count unchanged, miso_oe=0 within SYNC_STAGES+2 cycles, and the next full frame returns correct data.
- Assert sample_load with 8'h81 in the exact cycle the cs_n fall is detected. Required: the frame returns 8'h81.
- Preload frame_count to 16'hFFFF via 65535 frames (or a force in the bench), then run one more frame. Required: frame_count=0.
- Assert rst mid-frame after bit 5. Required: all outputs at reset values immediately, no frame_done, and correct data on the next frame after the cs_n fall.
